// File: rtl/serial_deserializer.sv
// serial_deserializer: packs qualified serial bits into WIDTH-bit words behind a one-entry valid/ready output register
module serial_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     data_in,
    input  logic                     bit_valid,
    input  logic                     clear,
    input  logic                     word_ready,
    input  logic                     ovf_clr,
    output logic [WIDTH-1:0]         word_out,
    output logic                     word_valid,
    output logic [$clog2(WIDTH)-1:0] bit_count,
    output logic                     overflow
);
    localparam int CW = $clog2(WIDTH);
    logic [WIDTH-1:0] shift_q, shift_d, word_q, word_d, next_word;
    logic [CW-1:0] cnt_q, cnt_d;
    logic valid_q, valid_d, ovf_q, ovf_d, take, done, free;
    always_comb begin
        next_word = MSB_FIRST ? {shift_q[WIDTH-2:0], data_in} : {data_in, shift_q[WIDTH-1:1]};
        take      = bit_valid && !clear;
        done      = take && (cnt_q == CW'(WIDTH - 1));
        free      = !valid_q || word_ready;
        shift_d   = clear ? '0 : take ? next_word : shift_q;
        cnt_d     = (clear || done) ? '0 : take ? cnt_q + CW'(1) : cnt_q;
        word_d    = (done && free) ? next_word : word_q;
        valid_d   = (done && free) ? 1'b1 : (valid_q && word_ready) ? 1'b0 : valid_q;
        ovf_d     = (done && !free) ? 1'b1 : ovf_clr ? 1'b0 : ovf_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            word_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end
    assign word_out   = word_q;
    assign word_valid = valid_q;
    assign bit_count  = cnt_q;
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_serial_deserializer.sv
// tb_serial_deserializer: MSB-first and LSB-first instances checked against a queue-based word model
module tb_serial_deserializer;
    localparam int W = 8;
    logic clk = 0, rst = 0, data_in = 0, bit_valid = 0, clear = 0, word_ready = 0, ovf_clr = 0;
    logic [W-1:0] wo_m, wo_l;
    logic wv_m, wv_l, ov_m, ov_l;
    logic [2:0] bc_m, bc_l;
    int passed = 0, total = 0;
    bit q[$];
    logic [W-1:0] m_wm, m_wl;
    bit m_v, m_o;
    logic [W-1:0] got[$];

    typedef struct {
        bit r, d, v, c, rdy, oc;
        logic [W-1:0] wm, wl;
        bit ev;
        int ec;
        bit eo;
    } vec_t;
    vec_t tbl[10];

    serial_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .data_in(data_in), .bit_valid(bit_valid), .clear(clear),
        .word_ready(word_ready), .ovf_clr(ovf_clr), .word_out(wo_m), .word_valid(wv_m),
        .bit_count(bc_m), .overflow(ov_m));
    serial_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .data_in(data_in), .bit_valid(bit_valid), .clear(clear),
        .word_ready(word_ready), .ovf_clr(ovf_clr), .word_out(wo_l), .word_valid(wv_l),
        .bit_count(bc_l), .overflow(ov_l));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_edge();
        logic [W-1:0] wm, wl;
        bit done, free;
        if (rst) begin
            q.delete();
            m_wm = '0; m_wl = '0; m_v = 0; m_o = 0;
        end else begin
            done = 0; wm = '0; wl = '0;
            free = !m_v || word_ready;
            if (clear) q.delete();
            else if (bit_valid) begin
                q.push_back(data_in);
                if (q.size() == W) begin
                    for (int i = 0; i < W; i++) begin
                        wm = wm | (W'(q[i]) << (W - 1 - i));
                        wl = wl | (W'(q[i]) << i);
                    end
                    done = 1;
                    q.delete();
                end
            end
            if (done && free) begin
                m_wm = wm; m_wl = wl; m_v = 1;
            end else if (m_v && word_ready) m_v = 0;
            if (done && !free) m_o = 1;
            else if (ovf_clr) m_o = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("word_msb", 32'(wo_m), 32'(m_wm));
        chk("word_lsb", 32'(wo_l), 32'(m_wl));
        chk("valid_msb", 32'(wv_m), 32'(m_v));
        chk("valid_lsb", 32'(wv_l), 32'(m_v));
        chk("count_msb", 32'(bc_m), 32'(q.size()));
        chk("count_lsb", 32'(bc_l), 32'(q.size()));
        chk("ovf_msb", 32'(ov_m), 32'(m_o));
        chk("ovf_lsb", 32'(ov_l), 32'(m_o));
    endtask

    task automatic send_word(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) begin
            data_in = w[i]; bit_valid = 1;
            step();
        end
        bit_valid = 0;
    endtask

    initial begin
        tbl[0] = '{1, 0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 0};
        tbl[1] = '{0, 1, 1, 0, 1, 0, 8'h00, 8'h00, 0, 1, 0};
        tbl[2] = '{0, 0, 1, 0, 1, 0, 8'h00, 8'h00, 0, 2, 0};
        tbl[3] = '{0, 1, 1, 0, 1, 0, 8'h00, 8'h00, 0, 3, 0};
        tbl[4] = '{0, 1, 1, 0, 1, 0, 8'h00, 8'h00, 0, 4, 0};
        tbl[5] = '{0, 0, 1, 0, 1, 0, 8'h00, 8'h00, 0, 5, 0};
        tbl[6] = '{0, 0, 1, 0, 1, 0, 8'h00, 8'h00, 0, 6, 0};
        tbl[7] = '{0, 1, 1, 0, 1, 0, 8'h00, 8'h00, 0, 7, 0};
        tbl[8] = '{0, 0, 1, 0, 1, 0, 8'hB2, 8'h4D, 1, 0, 0};
        tbl[9] = '{0, 0, 0, 0, 1, 0, 8'hB2, 8'h4D, 0, 0, 0};

        rst = 1; data_in = 1; bit_valid = 1; clear = 0; word_ready = 1; ovf_clr = 0;
        step();
        chk("reset_word", 32'(wo_m), 0);
        chk("reset_valid", 32'(wv_m), 0);
        chk("reset_count", 32'(bc_m), 0);
        chk("reset_ovf", 32'(ov_m), 0);
        data_in = 0; bit_valid = 0; word_ready = 0; ovf_clr = 1;
        step();
        rst = 0; ovf_clr = 0;

        for (int i = 0; i < 10; i++) begin
            rst = tbl[i].r; data_in = tbl[i].d; bit_valid = tbl[i].v;
            clear = tbl[i].c; word_ready = tbl[i].rdy; ovf_clr = tbl[i].oc;
            step();
            chk($sformatf("tbl%0d_word_msb", i), 32'(wo_m), 32'(tbl[i].wm));
            chk($sformatf("tbl%0d_word_lsb", i), 32'(wo_l), 32'(tbl[i].wl));
            chk($sformatf("tbl%0d_valid", i), 32'(wv_m), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_count", i), 32'(bc_m), 32'(tbl[i].ec));
            chk($sformatf("tbl%0d_ovf", i), 32'(ov_m), 32'(tbl[i].eo));
        end
        rst = 0; bit_valid = 0; clear = 0; ovf_clr = 0;

        word_ready = 0;
        send_word(8'hA5);
        chk("bp_first_word", 32'(wo_m), 32'hA5);
        chk("bp_first_valid", 32'(wv_m), 1);
        send_word(8'h3C);
        chk("ovf_word_kept", 32'(wo_m), 32'hA5);
        chk("ovf_set", 32'(ov_m), 1);
        chk("ovf_count_wrap", 32'(bc_m), 0);
        word_ready = 1;
        step();
        chk("bp_drain_valid", 32'(wv_m), 0);
        chk("ovf_sticky", 32'(ov_m), 1);
        word_ready = 0; ovf_clr = 1;
        step();
        ovf_clr = 0;
        chk("ovf_cleared", 32'(ov_m), 0);

        send_word(8'hC3);
        for (int i = W - 1; i >= 0; i--) begin
            data_in = 8'h96 >> i; bit_valid = 1; word_ready = (i == 0);
            step();
        end
        bit_valid = 0;
        chk("b2b_valid", 32'(wv_m), 1);
        chk("b2b_word", 32'(wo_m), 32'h96);
        chk("b2b_no_ovf", 32'(ov_m), 0);
        step();
        chk("b2b_drain", 32'(wv_m), 0);

        got.delete();
        word_ready = 1;
        for (int k = 0; k < 2; k++)
            for (int i = W - 1; i >= 0; i--) begin
                data_in = (k == 0) ? 1'b1 : (i == 0); bit_valid = 1;
                step();
                if (wv_m) got.push_back(wo_m);
                bit_valid = 0;
                step();
                if (wv_m) got.push_back(wo_m);
            end
        chk("gap_words", 32'(got.size()), 2);
        if (got.size() == 2) begin
            chk("gap_word0", 32'(got[0]), 32'hFF);
            chk("gap_word1", 32'(got[1]), 32'h01);
        end
        chk("gap_no_ovf", 32'(ov_m), 0);

        for (int i = 0; i < 3; i++) begin
            data_in = 1; bit_valid = 1;
            step();
        end
        clear = 1;
        step();
        clear = 0;
        chk("clear_count", 32'(bc_m), 0);
        send_word(8'h81);
        chk("clear_word", 32'(wo_m), 32'h81);
        chk("clear_valid", 32'(wv_m), 1);

        for (int i = 0; i < 5; i++) begin
            data_in = 1; bit_valid = 1;
            step();
        end
        chk("pre_rst_count", 32'(bc_m), 5);
        rst = 1;
        step();
        rst = 0;
        chk("rst_count", 32'(bc_m), 0);
        send_word(8'h5A);
        chk("rst_align_word", 32'(wo_m), 32'h5A);

        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            clear = ($urandom_range(0, 39) == 0);
            ovf_clr = ($urandom_range(0, 29) == 0);
            bit_valid = ($urandom_range(0, 9) < 6);
            word_ready = ($urandom_range(0, 9) < 4);
            data_in = $urandom_range(0, 1);
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/serial_deserializer.md
Name: serial_deserializer

Overview:
Serial-to-parallel stage that sits directly downstream of the serial shift register. It consumes that register's serial output one bit per qualified clock and packs the bits into WIDTH-bit words. Completed words go out over a valid/ready handshake through a one-entry output holding register. Frame alignment is controlled by an explicit clear input, and lost words are reported through a sticky overflow flag.

Parameters:
WIDTH, 8, bits per assembled word; legal range 2..32.
MSB_FIRST, 1, 1 = the first received bit lands in word_out[WIDTH-1]; 0 = the first received bit lands in word_out[0].

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
data_in  input  1  serial bit from the upstream shift register.
bit_valid  input  1  data_in is sampled only on edges where this is 1.
clear  input  1  discards any partial word and restarts the frame at bit 0.
word_ready  input  1  downstream can accept word_out.
word_out  output  WIDTH  assembled word; stable while word_valid=1.
word_valid  output  1  word_out holds an unconsumed word.
bit_count  output  $clog2(WIDTH)  number of bits in the current partial word, 0..WIDTH-1.
overflow  output  1  sticky flag: a completed word was dropped.
ovf_clr  input  1  clears overflow.

Behaviour:
- Reset (rst=1 at an edge): word_out=0, word_valid=0, bit_count=0, overflow=0, partial shift register=0. Reset overrides every other input and aborts any partial word or held word.
- Accumulate: on an edge with bit_valid=1 and clear=0, data_in is shifted into the partial register and bit_count increments.
  - MSB_FIRST=1: the partial register shifts left and the new bit enters the LSB.
  - MSB_FIRST=0: the partial register shifts right and the new bit enters the MSB.
- Completion: an edge with bit_valid=1 and bit_count=WIDTH-1 completes a word that includes the current bit.
  - bit_count wraps to 0 on that edge.
  - The partial register content is don't-care after completion.
- Output load on completion:
  - If the output register is free (word_valid=0, or word_valid=1 and word_ready=1 on the same edge), the completed word loads into word_out and word_valid is 1 from the next cycle.
  - Latency: word_valid rises one cycle after the edge that samples the last bit.
- Back-to-back: a handshake and a load on the same edge leave word_valid=1, and word_out takes the new word. There is no bubble.
- Handshake: a transfer happens on an edge where word_valid=1 and word_ready=1. If no new word loads on that edge, word_valid goes to 0 on the next cycle.
  - word_out is not modified while word_valid=1 and word_ready=0.
  - word_ready has no effect while word_valid=0.
- Overflow: a completion while word_valid=1 and word_ready=0 drops the new word.
  - word_out is unchanged and overflow is set to 1.
  - bit_count still wraps to 0.
- overflow stays 1 until rst or ovf_clr. If ovf_clr and a new overflow event occur on the same edge, the set wins (overflow=1).
- clear: on an edge with clear=1, bit_count=0 and the partial word is discarded.
  - If bit_valid=1 on the same edge, clear wins and that bit is discarded.
  - clear does not affect word_out, word_valid or overflow.
- bit_valid=0: the partial register and bit_count hold.
- Gaps between valid bits are unbounded and do not break framing.
- There is no timeout. Framing is restored only by clear or rst.

Test Plan:
- Reset: drive rst=1 for 2 cycles with random inputs -> word_out=0, word_valid=0, bit_count=0, overflow=0 on the cycle after the first reset edge.
- Basic word (WIDTH=8, MSB_FIRST=1, word_ready=1): send 1,0,1,1,0,0,1,0 on consecutive cycles -> word_out=8'hB2 and word_valid=1 for exactly one cycle, one cycle after the 8th bit; bit_count steps 0..7 then returns to 0.
- LSB-first (MSB_FIRST=0): send the same bit sequence -> word_out=8'h4D.
- Backpressure and overflow: hold word_ready=0 and send two words 8'hA5 then 8'h3C -> word_out stays 8'hA5 and overflow=1 after the 16th bit. Then assert word_ready for 1 cycle -> word_valid=0 on the next cycle. Then pulse ovf_clr -> overflow=0.
- Back-to-back with gaps: word_ready=1, send 8'hFF then 8'h01 with bit_valid toggling 1,0,1,0 -> two words are delivered with correct values and no overflow. A completion landing on a handshake edge keeps word_valid=1 without a bubble.
- Mid-frame clear: send 3 bits, then clear=1 together with bit_valid=1, then 8 bits forming 8'h81 -> word_out=8'h81; the 3 earlier bits and the bit coincident with clear never appear in any word. A separate run asserts rst at bit_count=5 -> the next word is aligned to the first bit sent after reset.
